// File: rtl/vstore_bank_scheduler_pkg.sv
// store_pkg: shared definitions for the banked store scheduler.
//   store_sel_e  - scalar store-size encodings (SB/SH/SW/NONE)
//   scalar_be    - byte enables plus misaligned flag for a scalar store
//   bank_of      - bank index field of a byte address
//   row_of       - bank-local word row of a byte address
package store_pkg;

  typedef enum logic [1:0] {
    SEL_SB   = 2'd0,
    SEL_SH   = 2'd1,
    SEL_SW   = 2'd2,
    SEL_NONE = 2'd3
  } store_sel_e;

  typedef struct packed {
    logic [3:0] be;
    logic       misaligned;
  } scalar_be_t;

  // A misaligned or no-write request returns be = 0, so callers can use
  // be != 0 as "this request writes".
  function automatic scalar_be_t scalar_be(input store_sel_e sel, input logic [1:0] offset);
    scalar_be_t r;
    r.be         = '0;
    r.misaligned = 1'b0;
    case (sel)
      SEL_SB: r.be = 4'b0001 << offset;
      SEL_SH: begin
        if (offset[0]) r.misaligned = 1'b1;
        else           r.be = 4'b0011 << offset;
      end
      SEL_SW: begin
        if (offset != 2'd0) r.misaligned = 1'b1;
        else                r.be = 4'hF;
      end
      default: r.be = '0;
    endcase
    return r;
  endfunction

  // Results are 32 bits wide; callers slice to their field width.
  function automatic logic [31:0] bank_of(input logic [31:0] addr, input int unsigned bank_bits);
    return (addr >> 2) & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] row_of(input logic [31:0] addr, input int unsigned bank_bits);
    return addr >> (2 + bank_bits);
  endfunction

endpackage

// File: rtl/vstore_bank_scheduler_if.sv
// vstore_bank_scheduler_if: request handshake, banked memory write port and
// status signals of the store scheduler.
//   master: request producer / memory-side observer
//   slave : the scheduler itself
interface vstore_bank_scheduler_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 14
);
  localparam int unsigned ROW_W = ADDR_W - 2 - $clog2(NUM_BANKS);

  logic                      req_valid;
  logic                      req_ready;
  logic                      req_is_vector;
  logic [1:0]                req_store_select;
  logic [NUM_LANES-1:0]      req_lane_mask;
  logic [NUM_LANES*ADDR_W-1:0] req_addr;
  logic [NUM_LANES*32-1:0]   req_data;
  logic [NUM_BANKS*4-1:0]    bank_we;
  logic [NUM_BANKS*ROW_W-1:0] bank_row;
  logic [NUM_BANKS*32-1:0]   bank_wdata;
  logic                      busy;
  logic                      done;
  logic                      misaligned;

  modport master (
    output req_valid, req_is_vector, req_store_select, req_lane_mask, req_addr, req_data,
    input  req_ready, bank_we, bank_row, bank_wdata, busy, done, misaligned
  );

  modport slave (
    input  req_valid, req_is_vector, req_store_select, req_lane_mask, req_addr, req_data,
    output req_ready, bank_we, bank_row, bank_wdata, busy, done, misaligned
  );
endinterface

// File: rtl/vstore_bank_scheduler_arbiter.sv
// store_bank_arbiter: fixed-priority grant for one memory bank.
//   pend_i      - pending lane mask
//   lane_bank_i - bank field of each lane, lane i at [i*BANK_W +: BANK_W]
//   grant_o     - one-hot grant of the lowest-index pending lane on BANK_ID
module store_bank_arbiter #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned BANK_W    = 2,
  parameter int unsigned BANK_ID   = 0
) (
  input  logic [NUM_LANES-1:0]        pend_i,
  input  logic [NUM_LANES*BANK_W-1:0] lane_bank_i,
  output logic [NUM_LANES-1:0]        grant_o
);
  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (!found && pend_i[l] && (lane_bank_i[l*BANK_W +: BANK_W] == BANK_W'(BANK_ID))) begin
        grant_o[l] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/vstore_bank_scheduler.sv
// vstore_bank_scheduler: routes a scalar or vector store onto single-port
// memory banks, serialising lanes that collide on a bank.
//   clk, rst - clock and synchronous active-high reset
//   bus      - request handshake, per-bank write port, busy/done/misaligned
module vstore_bank_scheduler
  import store_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 14
) (
  input logic                    clk,
  input logic                    rst,
  vstore_bank_scheduler_if.slave bus
);
  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned ROW_W  = ADDR_W - 2 - BANK_W;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e                              state_q, state_d;
  logic [NUM_LANES-1:0]                pend_q, pend_d;
  logic [NUM_LANES-1:0][BANK_W-1:0]    bank_q;
  logic [NUM_LANES-1:0][ROW_W-1:0]     row_q;
  logic [NUM_LANES-1:0][31:0]          data_q;
  logic [3:0]                          be_q;
  logic                                mis_q;

  logic [NUM_LANES-1:0][BANK_W-1:0]    cap_bank;
  logic [NUM_LANES-1:0][ROW_W-1:0]     cap_row;
  logic [NUM_LANES-1:0][31:0]          cap_data;
  logic [NUM_LANES-1:0]                cap_pend;
  logic [3:0]                          cap_be;
  logic                                cap_mis;
  logic [31:0]                         a32, fld, op;
  scalar_be_t                          sbe;
  logic                                accept;

  logic [NUM_LANES-1:0]                pend_act;
  logic [NUM_BANKS-1:0][NUM_LANES-1:0] grant;
  logic [NUM_LANES-1:0]                granted;

  assign accept = (state_q == S_IDLE) && bus.req_valid;

  // Scalar size masking, shifting and legality are resolved at capture, so
  // a misaligned or no-write scalar simply enters ISSUE with nothing pending.
  always_comb begin
    cap_bank = '0;
    cap_row  = '0;
    cap_data = '0;
    cap_pend = '0;
    cap_be   = '0;
    cap_mis  = 1'b0;
    a32      = '0;
    fld      = '0;
    op       = '0;
    sbe      = scalar_be(store_sel_e'(bus.req_store_select), bus.req_addr[1:0]);
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      a32         = 32'(bus.req_addr[l*ADDR_W +: ADDR_W]);
      fld         = bank_of(a32, BANK_W);
      cap_bank[l] = fld[BANK_W-1:0];
      fld         = row_of(a32, BANK_W);
      cap_row[l]  = fld[ROW_W-1:0];
      cap_data[l] = bus.req_data[l*32 +: 32];
    end
    if (bus.req_is_vector) begin
      cap_pend = bus.req_lane_mask;
      cap_be   = 4'hF;
    end else begin
      case (store_sel_e'(bus.req_store_select))
        SEL_SB:  op = bus.req_data[31:0] & 32'h0000_00FF;
        SEL_SH:  op = bus.req_data[31:0] & 32'h0000_FFFF;
        default: op = bus.req_data[31:0];
      endcase
      cap_data[0] = op << {bus.req_addr[1:0], 3'b000};
      cap_be      = sbe.be;
      cap_mis     = sbe.misaligned;
      cap_pend[0] = (sbe.be != 4'h0);
    end
  end

  assign pend_act = (state_q == S_ISSUE) ? pend_q : '0;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
    store_bank_arbiter #(
      .NUM_LANES(NUM_LANES),
      .BANK_W   (BANK_W),
      .BANK_ID  (b)
    ) u_arb (
      .pend_i     (pend_act),
      .lane_bank_i(bank_q),
      .grant_o    (grant[b])
    );
  end

  always_comb begin
    granted        = '0;
    bus.bank_we    = '0;
    bus.bank_row   = '0;
    bus.bank_wdata = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      granted = granted | grant[b];
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (grant[b][l]) begin
          bus.bank_we[b*4 +: 4]        = be_q;
          bus.bank_row[b*ROW_W +: ROW_W] = row_q[l];
          bus.bank_wdata[b*32 +: 32]   = data_q[l];
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q;
    bus.done       = 1'b0;
    bus.misaligned = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          state_d = S_ISSUE;
          pend_d  = cap_pend;
        end
      end
      S_ISSUE: begin
        pend_d = pend_q & ~granted;
        if (pend_d == '0) begin
          bus.done       = 1'b1;
          bus.misaligned = mis_q;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      data_q  <= '0;
      be_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (accept) begin
        bank_q <= cap_bank;
        row_q  <= cap_row;
        data_q <= cap_data;
        be_q   <= cap_be;
        mis_q  <= cap_mis;
      end
    end
  end
endmodule

// File: tb/tb_vstore_bank_scheduler.sv
// Testbench for vstore_bank_scheduler: directed requests with hand-computed
// per-cycle expectations queued at issue and checked by a monitor.
module tb_vstore_bank_scheduler;
  localparam int unsigned NL = 4;
  localparam int unsigned NB = 4;
  localparam int unsigned AW = 14;
  localparam int unsigned RW = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  vstore_bank_scheduler_if #(.NUM_LANES(NL), .NUM_BANKS(NB), .ADDR_W(AW)) bus ();

  vstore_bank_scheduler #(.NUM_LANES(NL), .NUM_BANKS(NB), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [NB*4-1:0]  we;
    logic [NB*RW-1:0] row;
    logic [NB*32-1:0] wdata;
    logic             done;
    logic             mis;
  } exp_t;

  exp_t q[$];

  function automatic exp_t blank();
    exp_t e;
    e.we = '0; e.row = '0; e.wdata = '0; e.done = 1'b0; e.mis = 1'b0;
    return e;
  endfunction

  function automatic exp_t wr(exp_t e, int unsigned b, logic [3:0] we, logic [RW-1:0] row, logic [31:0] d);
    e.we[b*4 +: 4]    = we;
    e.row[b*RW +: RW] = row;
    e.wdata[b*32 +: 32] = d;
    return e;
  endfunction

  function automatic exp_t fin(exp_t e, logic mis);
    e.done = 1'b1;
    e.mis  = mis;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: while busy each cycle must match the next queued expectation;
  // while idle the bank port and status outputs must be quiet.
  initial begin
    exp_t e;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (bus.busy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue_cycle: busy with no expectation at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("bank_we",    128'(bus.bank_we),    128'(e.we));
          chk("bank_row",   128'(bus.bank_row),   128'(e.row));
          chk("bank_wdata", 128'(bus.bank_wdata), 128'(e.wdata));
          chk("done",       128'(bus.done),       128'(e.done));
          chk("misaligned", 128'(bus.misaligned), 128'(e.mis));
        end
      end else begin
        chk("idle_we",    128'(bus.bank_we),    128'(0));
        chk("idle_wdata", 128'(bus.bank_wdata), 128'(0));
        chk("idle_done",  128'(bus.done),       128'(0));
        chk("idle_ready", 128'(bus.req_ready),  128'(1));
      end
    end
  end

  task automatic drive(input logic isvec, input logic [1:0] sel, input logic [3:0] mask,
                       input logic [AW-1:0] a0, a1, a2, a3,
                       input logic [31:0] d0, d1, d2, d3);
    bus.req_is_vector    = isvec;
    bus.req_store_select = sel;
    bus.req_lane_mask    = mask;
    bus.req_addr         = {a3, a2, a1, a0};
    bus.req_data         = {d3, d2, d1, d0};
    chk("ready_before_req", 128'(bus.req_ready), 128'(1));
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid        = 1'b0;
    bus.req_is_vector    = 1'($urandom);
    bus.req_store_select = 2'($urandom);
    bus.req_lane_mask    = 4'($urandom);
    bus.req_addr         = {2{28'($urandom)}};
    bus.req_data         = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send(input logic isvec, input logic [1:0] sel, input logic [3:0] mask,
                      input logic [AW-1:0] a0, a1, a2, a3,
                      input logic [31:0] d0, d1, d2, d3);
    int n = 0;
    drive(isvec, sel, mask, a0, a1, a2, a3, d0, d1, d2, d3);
    while (bus.busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: still busy after %0d cycles", n);
    end
    chk("queue_drained", 128'(q.size()), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_is_vector = 1'b0; bus.req_store_select = '0;
    bus.req_lane_mask = '0; bus.req_addr = '0; bus.req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(bus.req_ready), 128'(1));
    chk("rst_busy",  128'(bus.busy),      128'(0));
    chk("rst_done",  128'(bus.done),      128'(0));
    chk("rst_mis",   128'(bus.misaligned), 128'(0));
    chk("rst_we",    128'(bus.bank_we),   128'(0));
    chk("rst_row",   128'(bus.bank_row),  128'(0));
    chk("rst_wdata", 128'(bus.bank_wdata), 128'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // SB at 0x6: bank 1, row 0, offset 2
    q.push_back(fin(wr(blank(), 1, 4'b0100, 10'd0, 32'h00AB_0000), 1'b0));
    send(1'b0, 2'd0, 4'hF, 14'h0006, 14'h0010, 14'h0020, 14'h0030,
         32'h0000_00AB, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);

    // SW misaligned at 0x2
    q.push_back(fin(blank(), 1'b1));
    send(1'b0, 2'd2, 4'hF, 14'h0002, 14'h0004, 14'h0008, 14'h000C,
         32'hCAFE_F00D, 32'h1, 32'h2, 32'h3);
    chk("ready_after_misaligned", 128'(bus.req_ready), 128'(1));

    // SH at 0xA: bank 2, offset 2
    q.push_back(fin(wr(blank(), 2, 4'b1100, 10'd0, 32'hCDEF_0000), 1'b0));
    send(1'b0, 2'd1, 4'h0, 14'h000A, 14'h0, 14'h0, 14'h0,
         32'h1234_CDEF, 32'h0, 32'h0, 32'h0);

    // SH misaligned at 0x5
    q.push_back(fin(blank(), 1'b1));
    send(1'b0, 2'd1, 4'h1, 14'h0005, 14'h0, 14'h0, 14'h0,
         32'h0000_BEEF, 32'h0, 32'h0, 32'h0);

    // SB at 0x13: bank 0, row 1, offset 3, upper data bits dropped
    q.push_back(fin(wr(blank(), 0, 4'b1000, 10'd1, 32'h5A00_0000), 1'b0));
    send(1'b0, 2'd0, 4'h0, 14'h0013, 14'h0, 14'h0, 14'h0,
         32'hFFFF_FF5A, 32'h0, 32'h0, 32'h0);

    // store_select = 3: no write, not misaligned
    q.push_back(fin(blank(), 1'b0));
    send(1'b0, 2'd3, 4'hF, 14'h0004, 14'h0008, 14'h0, 14'h0,
         32'h1234_5678, 32'h9, 32'h0, 32'h0);

    // SW at top of address space: bank 3, row 0x3FF
    q.push_back(fin(wr(blank(), 3, 4'hF, 10'h3FF, 32'hDEAD_BEEF), 1'b0));
    send(1'b0, 2'd2, 4'h0, 14'h3FFC, 14'h0, 14'h0, 14'h0,
         32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);

    // Vector, one lane per bank, store_select ignored
    q.push_back(fin(wr(wr(wr(wr(blank(), 0, 4'hF, 10'd0, 32'd1), 1, 4'hF, 10'd0, 32'd2),
                          2, 4'hF, 10'd0, 32'd3), 3, 4'hF, 10'd0, 32'd4), 1'b0));
    send(1'b1, 2'd3, 4'b1111, 14'h0000, 14'h0004, 14'h0008, 14'h000C,
         32'd1, 32'd2, 32'd3, 32'd4);

    // Vector, all lanes on bank 0: serialised in lane order
    q.push_back(wr(blank(), 0, 4'hF, 10'd0, 32'hA0));
    q.push_back(wr(blank(), 0, 4'hF, 10'd1, 32'hA1));
    q.push_back(wr(blank(), 0, 4'hF, 10'd2, 32'hA2));
    q.push_back(fin(wr(blank(), 0, 4'hF, 10'd3, 32'hA3), 1'b0));
    send(1'b1, 2'd0, 4'b1111, 14'h0000, 14'h0010, 14'h0020, 14'h0030,
         32'hA0, 32'hA1, 32'hA2, 32'hA3);

    // Vector, mask 0101: lanes 0 and 2 collide on bank 2
    q.push_back(wr(blank(), 2, 4'hF, 10'd0, 32'hB0));
    q.push_back(fin(wr(blank(), 2, 4'hF, 10'd1, 32'hB2), 1'b0));
    send(1'b1, 2'd0, 4'b0101, 14'h0008, 14'h0004, 14'h0018, 14'h000C,
         32'hB0, 32'hB1, 32'hB2, 32'hB3);

    // Vector, empty mask
    q.push_back(fin(blank(), 1'b0));
    send(1'b1, 2'd2, 4'b0000, 14'h0000, 14'h0004, 14'h0008, 14'h000C,
         32'h5, 32'h6, 32'h7, 32'h8);

    // Vector with offset bits set: full-word writes, bank 1 collides
    q.push_back(wr(wr(wr(blank(), 0, 4'hF, 10'd0, 32'hC3), 1, 4'hF, 10'd0, 32'hC0),
                   3, 4'hF, 10'h3FF, 32'hC2));
    q.push_back(fin(wr(blank(), 1, 4'hF, 10'd4, 32'hC1), 1'b0));
    send(1'b1, 2'd0, 4'b1111, 14'h0007, 14'h0045, 14'h3FFC, 14'h0001,
         32'hC0, 32'hC1, 32'hC2, 32'hC3);

    // Reset in T+2 of a 4-way conflict: nothing after T+2
    q.push_back(wr(blank(), 0, 4'hF, 10'd0, 32'hD0));
    q.push_back(wr(blank(), 0, 4'hF, 10'd1, 32'hD1));
    drive(1'b1, 2'd0, 4'b1111, 14'h0000, 14'h0010, 14'h0020, 14'h0030,
          32'hD0, 32'hD1, 32'hD2, 32'hD3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_busy",  128'(bus.busy),      128'(0));
    chk("rst_mid_ready", 128'(bus.req_ready), 128'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_queue", 128'(q.size()), 128'(0));

    // Recovery after reset: SB at 0x30, bank 0, row 3
    q.push_back(fin(wr(blank(), 0, 4'b0001, 10'd3, 32'h0000_0077), 1'b0));
    send(1'b0, 2'd0, 4'h0, 14'h0030, 14'h0, 14'h0, 14'h0,
         32'h1234_5677, 32'h0, 32'h0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("final_queue", 128'(q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vstore_bank_scheduler.md
# vstore_bank_scheduler

Parametrised store unit between the execute/VLSU stage and the banked data memory. Accepts a scalar store (byte/half/word, little-endian byte enables) or a vector store of up to NUM_LANES word elements. Elements are routed to NUM_BANKS single-port banks by word address. Elements that collide on a bank are serialised over successive cycles, and completion is reported with a done pulse.

## Interface
- NUM_LANES, 4: vector elements per request (≥1)
- NUM_BANKS, 4: memory banks, power of 2 (≥2)
- ADDR_W, 14: byte-address width per element
- ROW_W, ADDR_W-2-log2(NUM_BANKS): derived, bank-local word row width
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  request accepted when req_valid && req_ready
- req_is_vector  in  1  1 = vector store, 0 = scalar store (lane 0 only)
- req_store_select  in  2  scalar size: 0 = SB, 1 = SH, 2 = SW, 3 = no write; ignored for vector
- req_lane_mask  in  NUM_LANES  per-lane enable (vector only)
- req_addr  in  NUM_LANES*ADDR_W  per-lane byte address, lane i at [i*ADDR_W +: ADDR_W]
- req_data  in  NUM_LANES*32  per-lane store data
- bank_we  out  NUM_BANKS*4  per-bank byte write enables
- bank_row  out  NUM_BANKS*ROW_W  per-bank word row
- bank_wdata  out  NUM_BANKS*32  per-bank write data
- busy  out  1  request in flight
- done  out  1  one-cycle pulse in the cycle of the request's final write slot
- misaligned  out  1  pulses with done when a scalar request was misaligned

## Operation
- Address split: bank = addr[2 +: log2(NUM_BANKS)]; row = addr[ADDR_W-1 : 2+log2(NUM_BANKS)]; byte offset = addr[1:0].
- States: IDLE and ISSUE.
- IDLE: req_ready = 1.
  - On acceptance, capture addresses, data, size and the pending mask, then go to ISSUE.
  - Vector pending mask = req_lane_mask.
  - Scalar pending mask = lane 0 only.
- ISSUE: for each bank, grant the lowest-index pending lane whose bank field matches.
  - Drive that lane's row and data on the bank; clear granted lanes at the clock edge.
  - Ungranted banks drive we = 0, row = 0, wdata = 0.
- Done condition: done = 1 in the ISSUE cycle where all still-pending lanes are granted. The next state is IDLE.
- Vector writes: full word, we = 4'hF, data unmodified. Offset bits [1:0] are ignored.
- Scalar writes: data = size-masked operand << (8*offset). Byte enables:
  - SB: be = 1 << offset.
  - SH: be = 4'b0011 << offset; legal offsets 0 and 2.
  - SW: be = 4'hF; legal offset 0.
- Misaligned scalar (SH at odd offset, SW at nonzero offset): no write issued; done and misaligned pulse in the single ISSUE cycle.
- store_select = 3: treated as an aligned no-write. Single ISSUE cycle, done = 1, misaligned = 0.
- Empty vector mask: single ISSUE cycle, no writes, done = 1.

## Timing
- Reset values: req_ready = 1 (IDLE), busy = 0, done = 0, misaligned = 0, all bank_we/bank_row/bank_wdata = 0.
- Reset mid-operation: pending lanes are discarded and no further writes occur. The cycle after rst is in IDLE.
- All bank outputs are functions of registered state only; nothing is combinational from req_* to bank_*.
- Latency: accept at edge T, first write slot in cycle T+1. ISSUE lasts C cycles, where C = max over banks of the number of pending lanes mapped to that bank (C = 1 if no lanes).
- busy = 1 exactly during ISSUE; req_ready = !busy. Back-to-back requests therefore cost C+1 cycles each.
- Inputs are sampled only at acceptance; req_* may change freely afterwards.

## Structure
- Shared package store_pkg:
  - store-select encodings SB/SH/SW/NONE.
  - function scalar_be(select, offset) returning the 4-bit enable plus a misaligned flag.
  - function bank_of(addr) and function row_of(addr).
- One sub-module, store_bank_arbiter: an instance per bank. Takes the pending mask and per-lane bank fields, and returns a one-hot grant for the lowest-index matching lane. The top ORs the grants to clear pending bits.

## Test plan
- Scalar SB, data 0x000000AB, addr 0x0006 (bank 1, row 0, offset 2) -> cycle T+1: bank_we[bank1] = 4'b0100, wdata = 0x00AB0000, done = 1, misaligned = 0.
- Scalar SW at addr 0x0002 -> no bank_we asserted; done = 1 and misaligned = 1 in cycle T+1; req_ready = 1 in cycle T+2.
- Vector, mask 4'b1111, addrs 0x00/0x04/0x08/0x0C, data 1..4 -> all four banks write 4'hF, row 0, data 1..4 in one cycle; done = 1 in T+1.
- Vector, all lanes to bank 0, addrs 0x00/0x10/0x20/0x30 -> rows 0, 1, 2, 3 written in cycles T+1..T+4 in lane order; done only in T+4; busy = 1 for 4 cycles.
- Vector, mask 4'b0101 with lanes 0 and 2 on bank 2 and lanes 1 and 3 on other banks -> only lanes 0 and 2 write, in T+1 and T+2; masked lanes never write.
- rst asserted in T+2 of the conflict case -> no writes from T+3 on; done never pulses; req_ready = 1 in T+3.
